// File: rtl/i2c_package.sv
// Shared register map, status bit positions, sequencer state and command-entry layout
// for i2c_fifo_top and its FIFOs.
package i2c_package;

  localparam logic [2:0] ADR_PRER_LO  = 3'd0;
  localparam logic [2:0] ADR_PRER_HI  = 3'd1;
  localparam logic [2:0] ADR_CTR      = 3'd2;
  localparam logic [2:0] ADR_TXR      = 3'd3;
  localparam logic [2:0] ADR_RXR      = 3'd3;
  localparam logic [2:0] ADR_CMD_PUSH = 3'd4;
  localparam logic [2:0] ADR_SR       = 3'd4;
  localparam logic [2:0] ADR_CMD_LVL  = 3'd5;
  localparam logic [2:0] ADR_RX_LVL   = 3'd6;
  localparam logic [2:0] ADR_CMDR     = 3'd6;
  localparam logic [2:0] ADR_RXTHR    = 3'd7;

  localparam int SR_IRQ      = 0;
  localparam int SR_TIP      = 1;
  localparam int SR_RX_EMPTY = 2;
  localparam int SR_CMD_FULL = 3;
  localparam int SR_NACK     = 4;
  localparam int SR_AL       = 5;
  localparam int SR_BUSY     = 6;
  localparam int SR_RXACK    = 7;

  localparam int CTR_EN     = 7;
  localparam int CTR_IEN    = 6;
  localparam int CMDR_IACK  = 0;
  localparam int CMDR_FLUSH = 1;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_BUSY = 1'b1
  } seq_state_e;

  typedef struct packed {
    logic       sta;
    logic       sto;
    logic       rd;
    logic       wr;
    logic       ack;
    logic [7:0] data;
  } cmd_entry_t;

  localparam int CMD_W = $bits(cmd_entry_t);

  // Flags arrive as the top five bits of the push write: STA, STO, RD, WR, ACK.
  function automatic cmd_entry_t make_cmd(input logic [4:0] flags, input logic [7:0] data);
    cmd_entry_t e;
    e.sta  = flags[4];
    e.sto  = flags[3];
    e.rd   = flags[2];
    e.wr   = flags[1];
    e.ack  = flags[0];
    e.data = data;
    return e;
  endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Single-clock FIFO with occupancy counter; flush overrides a same-cycle push or pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module i2c_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_d = level_q + LW'(1);
      else if (do_pop && !do_push) level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: an entry is only ever read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/i2c_fifo_top.sv
// Wishbone front end that queues byte-controller commands and buffers received bytes.
// Define I2C_NACK_ABORT_EN to abort the queued commands when a write is NACKed.
module i2c_fifo_top
  import i2c_package::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] PRER_RST   = 16'hFFFF
) (
  input  logic        wb_clk_i,
  input  logic        arst_i,
  input  logic [2:0]  wb_adr_i,
  input  logic [7:0]  wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic [7:0]  wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_inta_o,
  output logic        bc_ena,
  output logic [15:0] bc_clk_cnt,
  output logic        bc_start,
  output logic        bc_stop,
  output logic        bc_read,
  output logic        bc_write,
  output logic        bc_ack_in,
  output logic [7:0]  bc_din,
  input  logic        bc_cmd_ack,
  input  logic        bc_ack_out,
  input  logic [7:0]  bc_dout,
  input  logic        bc_al,
  input  logic        bc_busy
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic        ack_q, ack_d;
  logic [15:0] prer_q, prer_d;
  logic        en_q, en_d;
  logic        ien_q, ien_d;
  logic [7:0]  txr_q, txr_d;
  logic [7:0]  rxthr_q, rxthr_d;
  seq_state_e  state_q, state_d;
  cmd_entry_t  cur_q, cur_d;
  logic        al_q, al_d;
  logic        rxack_q, rxack_d;
  logic        nack_q, nack_d;
  logic        irq_q, irq_d;
  logic        inta_q, inta_d;

  logic        wb_wr, wb_rd, iack, flush;
  logic        cmd_push, cmd_pop, cmd_flush, cmd_full, cmd_empty;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [CMD_W-1:0] cmd_dout;
  logic [7:0]  rx_dout;
  logic [LW-1:0] cmd_level, rx_level;
  cmd_entry_t  cmd_head, cmd_new;
  logic        busy, issue, done, nack_set, irq_set;
  logic [7:0]  sr, rd_data;

  // Register accesses take effect only in the cycle the ack is presented.
  assign wb_wr    = wb_cyc_i & wb_stb_i & wb_we_i & ack_q;
  assign wb_rd    = wb_cyc_i & wb_stb_i & ~wb_we_i & ack_q;
  assign iack     = wb_wr & (wb_adr_i == ADR_CMDR) & wb_dat_i[CMDR_IACK];
  assign flush    = wb_wr & (wb_adr_i == ADR_CMDR) & wb_dat_i[CMDR_FLUSH];
  assign cmd_new  = make_cmd(wb_dat_i[7:3], txr_q);
  assign cmd_push = wb_wr & (wb_adr_i == ADR_CMD_PUSH) & en_q & ~cmd_full;
  assign rx_pop   = wb_rd & (wb_adr_i == ADR_RXR) & ~rx_empty;
  assign cmd_head = cmd_entry_t'(cmd_dout);

  assign busy  = (state_q == SEQ_BUSY);
  assign done  = busy & bc_cmd_ack & en_q & ~bc_al;
  assign issue = ~busy & en_q & ~bc_al & ~flush & ~cmd_empty & ~(cmd_head.rd & rx_full);

`ifdef I2C_NACK_ABORT_EN
  assign nack_set = done & cur_q.wr & bc_ack_out;
`else
  assign nack_set = 1'b0;
`endif

  assign cmd_pop   = issue;
  assign rx_push   = done & cur_q.rd;
  assign cmd_flush = flush | bc_al | ~en_q | nack_set;

  assign irq_set = (done & cmd_empty) | bc_al |
                   ((rxthr_q != 8'd0) && (8'(rx_level) >= rxthr_q)) |
                   (nack_set & ~nack_q);

  always_comb begin
    ack_d   = wb_cyc_i & wb_stb_i & ~ack_q;
    prer_d  = prer_q;
    en_d    = en_q;
    ien_d   = ien_q;
    txr_d   = txr_q;
    rxthr_d = rxthr_q;
    if (wb_wr) begin
      case (wb_adr_i)
        ADR_PRER_LO: prer_d[7:0]  = wb_dat_i;
        ADR_PRER_HI: prer_d[15:8] = wb_dat_i;
        ADR_CTR: begin
          en_d  = wb_dat_i[CTR_EN];
          ien_d = wb_dat_i[CTR_IEN];
        end
        ADR_TXR:     txr_d   = wb_dat_i;
        ADR_RXTHR:   rxthr_d = wb_dat_i;
        default: ;
      endcase
    end
  end

  // Loss of arbitration or a disabled core drops any command in flight.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rxack_d = rxack_q;
    if (bc_al || !en_q) begin
      state_d = SEQ_IDLE;
      cur_d   = '0;
    end else if (done) begin
      state_d = SEQ_IDLE;
      cur_d   = '0;
      rxack_d = bc_ack_out;
    end else if (issue) begin
      state_d = SEQ_BUSY;
      cur_d   = cmd_head;
    end
  end

  always_comb begin
    al_d   = al_q;
    nack_d = nack_q;
    irq_d  = irq_q;
    if (bc_al) al_d = 1'b1;
    else if (cmd_push && cmd_new.sta) al_d = 1'b0;
    if (iack) nack_d = 1'b0;
    if (nack_set) nack_d = 1'b1;
    if (iack) irq_d = 1'b0;
    else if (irq_set) irq_d = 1'b1;
    inta_d = irq_q & ien_q;
  end

  always_comb begin
    sr              = '0;
    sr[SR_RXACK]    = rxack_q;
    sr[SR_BUSY]     = bc_busy;
    sr[SR_AL]       = al_q;
    sr[SR_NACK]     = nack_q;
    sr[SR_CMD_FULL] = cmd_full;
    sr[SR_RX_EMPTY] = rx_empty;
    sr[SR_TIP]      = busy | ~cmd_empty;
    sr[SR_IRQ]      = irq_q;
    case (wb_adr_i)
      ADR_PRER_LO: rd_data = prer_q[7:0];
      ADR_PRER_HI: rd_data = prer_q[15:8];
      ADR_CTR:     rd_data = {en_q, ien_q, 6'b0};
      ADR_RXR:     rd_data = rx_empty ? 8'h00 : rx_dout;
      ADR_SR:      rd_data = sr;
      ADR_CMD_LVL: rd_data = 8'(cmd_level);
      ADR_RX_LVL:  rd_data = 8'(rx_level);
      default:     rd_data = rxthr_q;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge arst_i) begin
    if (arst_i) begin
      ack_q   <= 1'b0;
      prer_q  <= PRER_RST;
      en_q    <= 1'b0;
      ien_q   <= 1'b0;
      txr_q   <= '0;
      rxthr_q <= '0;
      state_q <= SEQ_IDLE;
      cur_q   <= '0;
      al_q    <= 1'b0;
      rxack_q <= 1'b0;
      nack_q  <= 1'b0;
      irq_q   <= 1'b0;
      inta_q  <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      prer_q  <= prer_d;
      en_q    <= en_d;
      ien_q   <= ien_d;
      txr_q   <= txr_d;
      rxthr_q <= rxthr_d;
      state_q <= state_d;
      cur_q   <= cur_d;
      al_q    <= al_d;
      rxack_q <= rxack_d;
      nack_q  <= nack_d;
      irq_q   <= irq_d;
      inta_q  <= inta_d;
    end
  end

  i2c_sync_fifo #(.WIDTH(CMD_W), .DEPTH(FIFO_DEPTH)) u_cmd_fifo (
    .clk   (wb_clk_i),
    .rst   (arst_i),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .flush (cmd_flush),
    .din   (cmd_new),
    .dout  (cmd_dout),
    .full  (cmd_full),
    .empty (cmd_empty),
    .level (cmd_level)
  );

  i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (wb_clk_i),
    .rst   (arst_i),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .din   (bc_dout),
    .dout  (rx_dout),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_level)
  );

  assign wb_ack_o   = ack_q;
  assign wb_inta_o  = inta_q;
  assign wb_dat_o   = (ack_q & ~wb_we_i) ? rd_data : 8'h00;
  assign bc_ena     = en_q;
  assign bc_clk_cnt = prer_q;
  assign bc_start   = cur_q.sta;
  assign bc_stop    = cur_q.sto;
  assign bc_read    = cur_q.rd;
  assign bc_write   = cur_q.wr;
  assign bc_ack_in  = cur_q.ack;
  assign bc_din     = cur_q.data;

endmodule

// File: tb/tb_i2c_fifo_top.sv
// Directed self-checking bench for i2c_fifo_top; the test routine plays both the
// Wishbone master and the byte controller.
module tb_i2c_fifo_top;

  logic        wb_clk_i = 1'b0;
  logic        arst_i   = 1'b1;
  logic [2:0]  wb_adr_i = '0;
  logic [7:0]  wb_dat_i = '0;
  logic        wb_we_i  = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic [7:0]  wb_dat_o;
  logic        wb_ack_o;
  logic        wb_inta_o;
  logic        bc_ena;
  logic [15:0] bc_clk_cnt;
  logic        bc_start, bc_stop, bc_read, bc_write, bc_ack_in;
  logic [7:0]  bc_din;
  logic        bc_cmd_ack = 1'b0;
  logic        bc_ack_out = 1'b0;
  logic [7:0]  bc_dout    = '0;
  logic        bc_al      = 1'b0;
  logic        bc_busy    = 1'b0;

  int checkCount = 0;
  int passCount  = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  i2c_fifo_top #(.FIFO_DEPTH(8), .PRER_RST(16'hFFFF)) dut (
    .wb_clk_i   (wb_clk_i),
    .arst_i     (arst_i),
    .wb_adr_i   (wb_adr_i),
    .wb_dat_i   (wb_dat_i),
    .wb_we_i    (wb_we_i),
    .wb_stb_i   (wb_stb_i),
    .wb_cyc_i   (wb_cyc_i),
    .wb_dat_o   (wb_dat_o),
    .wb_ack_o   (wb_ack_o),
    .wb_inta_o  (wb_inta_o),
    .bc_ena     (bc_ena),
    .bc_clk_cnt (bc_clk_cnt),
    .bc_start   (bc_start),
    .bc_stop    (bc_stop),
    .bc_read    (bc_read),
    .bc_write   (bc_write),
    .bc_ack_in  (bc_ack_in),
    .bc_din     (bc_din),
    .bc_cmd_ack (bc_cmd_ack),
    .bc_ack_out (bc_ack_out),
    .bc_dout    (bc_dout),
    .bc_al      (bc_al),
    .bc_busy    (bc_busy)
  );

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic timeoutFail(input string tag);
    checkCount++;
    $display("[TB] FAIL %s: timed out waiting, expected the event within the cycle budget", tag);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  // Wishbone cycle: ack arrives one edge after the request, access lands on the next edge.
  task automatic wbAccess(input logic we, input logic [2:0] adr, input logic [7:0] dat,
                          output logic [7:0] rdata);
    int n;
    @(negedge wb_clk_i);
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    n = 0;
    rdata = 8'h00;
    do begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end while (!wb_ack_o && n < 8);
    if (!wb_ack_o) timeoutFail("wb_ack");
    rdata = wb_dat_o;
    @(posedge wb_clk_i);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [2:0] adr, input logic [7:0] dat);
    logic [7:0] unused;
    wbAccess(1'b1, adr, dat, unused);
  endtask

  task automatic wbRead(input logic [2:0] adr, output logic [7:0] rdata);
    wbAccess(1'b0, adr, 8'h00, rdata);
  endtask

  task automatic pushCmd(input logic [7:0] flags, input logic [7:0] data);
    wbWrite(3'd3, data);
    wbWrite(3'd4, flags);
  endtask

  task automatic waitBusy(input string tag);
    int n = 0;
    while (!(bc_start | bc_stop | bc_read | bc_write) && n < 20) begin
      @(posedge wb_clk_i);
      #1;
      n++;
    end
    if (!(bc_start | bc_stop | bc_read | bc_write)) timeoutFail(tag);
  endtask

  // Byte-controller completion pulse.
  task automatic applyStimulus(input logic ackOut, input logic [7:0] dout);
    @(negedge wb_clk_i);
    bc_cmd_ack = 1'b1;
    bc_ack_out = ackOut;
    bc_dout    = dout;
    @(negedge wb_clk_i);
    bc_cmd_ack = 1'b0;
    bc_ack_out = 1'b0;
    bc_dout    = 8'h00;
  endtask

  logic [7:0] rd;
  logic [7:0] rxExpect [8];

  initial begin
    // Reset values
    tick(3);
    checkOutput("rst_ack", {15'd0, wb_ack_o}, 16'd0);
    checkOutput("rst_inta", {15'd0, wb_inta_o}, 16'd0);
    checkOutput("rst_bc_cmd", {11'd0, bc_start, bc_stop, bc_read, bc_write, bc_ack_in}, 16'd0);
    checkOutput("rst_bc_din", {8'd0, bc_din}, 16'd0);
    checkOutput("rst_dat_o", {8'd0, wb_dat_o}, 16'd0);
    checkOutput("rst_clk_cnt", bc_clk_cnt, 16'hFFFF);
    @(negedge wb_clk_i);
    arst_i = 1'b0;
    checkOutput("rst_ena", {15'd0, bc_ena}, 16'd0);
    wbRead(3'd4, rd);
    checkOutput("rst_sr", {8'd0, rd}, 16'h0004);
    wbRead(3'd0, rd);
    checkOutput("rst_prer_lo", {8'd0, rd}, 16'h00FF);

    // Prescaler and dropped push while disabled
    wbWrite(3'd0, 8'h34);
    wbWrite(3'd1, 8'h12);
    checkOutput("prer_clk_cnt", bc_clk_cnt, 16'h1234);
    wbRead(3'd1, rd);
    checkOutput("prer_hi_rd", {8'd0, rd}, 16'h0012);
    pushCmd(8'h90, 8'h55);
    wbRead(3'd5, rd);
    checkOutput("push_while_dis", {8'd0, rd}, 16'h0000);
    wbWrite(3'd2, 8'hC0);
    checkOutput("ena_on", {15'd0, bc_ena}, 16'd1);
    wbRead(3'd2, rd);
    checkOutput("ctr_rd", {8'd0, rd}, 16'h00C0);

    // Two queued writes
    pushCmd(8'h90, 8'hA0);
    waitBusy("busy1");
    checkOutput("cmd1_flags", {11'd0, bc_start, bc_stop, bc_read, bc_write, bc_ack_in}, 16'h0012);
    checkOutput("cmd1_din", {8'd0, bc_din}, 16'h00A0);
    pushCmd(8'h10, 8'h10);
    wbRead(3'd5, rd);
    checkOutput("cmd_lvl_1", {8'd0, rd}, 16'h0001);
    bc_busy = 1'b1;
    wbRead(3'd4, rd);
    checkOutput("sr_busy_tip", {8'd0, rd}, 16'h0046);
    bc_busy = 1'b0;
    applyStimulus(1'b0, 8'h00);
    checkOutput("idle_gap_din", {8'd0, bc_din}, 16'h0000);
    waitBusy("busy2");
    checkOutput("cmd2_flags", {11'd0, bc_start, bc_stop, bc_read, bc_write, bc_ack_in}, 16'h0002);
    checkOutput("cmd2_din", {8'd0, bc_din}, 16'h0010);
    applyStimulus(1'b0, 8'h00);
    wbRead(3'd4, rd);
    checkOutput("sr_irq_done", {8'd0, rd}, 16'h0005);
    checkOutput("inta_done", {15'd0, wb_inta_o}, 16'd1);
    wbWrite(3'd6, 8'h01);
    wbRead(3'd4, rd);
    checkOutput("sr_after_iack", {8'd0, rd}, 16'h0004);
    checkOutput("inta_after_iack", {15'd0, wb_inta_o}, 16'd0);

    // Command FIFO overflow
    pushCmd(8'h10, 8'h01);
    waitBusy("busy_ovf");
    for (int i = 0; i < 9; i++) wbWrite(3'd4, 8'h10);
    wbRead(3'd5, rd);
    checkOutput("cmd_lvl_full", {8'd0, rd}, 16'h0008);
    wbRead(3'd4, rd);
    checkOutput("sr_full", {8'd0, rd}, 16'h000E);
    wbWrite(3'd2, 8'h40);
    tick(1);
    checkOutput("dis_write", {15'd0, bc_write}, 16'd0);
    wbRead(3'd5, rd);
    checkOutput("dis_flush_lvl", {8'd0, rd}, 16'h0000);
    wbWrite(3'd2, 8'hC0);

    // RX threshold interrupt and IACK priority
    wbWrite(3'd7, 8'h02);
    pushCmd(8'h20, 8'h00);
    wbWrite(3'd4, 8'h20);
    waitBusy("busy_rd1");
    applyStimulus(1'b0, 8'h11);
    wbRead(3'd4, rd);
    checkOutput("sr_rx_lvl1", {8'd0, rd}, 16'h0002);
    waitBusy("busy_rd2");
    applyStimulus(1'b0, 8'h22);
    wbWrite(3'd6, 8'h01);
    tick(1);
    checkOutput("iack_wins", {15'd0, wb_inta_o}, 16'd0);
    tick(1);
    checkOutput("thr_reset_irq", {15'd0, wb_inta_o}, 16'd1);
    wbRead(3'd4, rd);
    checkOutput("sr_thr", {8'd0, rd}, 16'h0001);
    wbRead(3'd6, rd);
    checkOutput("rx_lvl_2", {8'd0, rd}, 16'h0002);
    wbRead(3'd3, rd);
    checkOutput("rx_pop_11", {8'd0, rd}, 16'h0011);
    wbRead(3'd3, rd);
    checkOutput("rx_pop_22", {8'd0, rd}, 16'h0022);
    wbRead(3'd3, rd);
    checkOutput("rx_empty_rd", {8'd0, rd}, 16'h0000);
    wbRead(3'd6, rd);
    checkOutput("rx_lvl_0", {8'd0, rd}, 16'h0000);
    wbWrite(3'd6, 8'h01);
    wbRead(3'd4, rd);
    checkOutput("sr_thr_clr", {8'd0, rd}, 16'h0004);
    wbWrite(3'd7, 8'h00);

    // RX full blocks a read command until one byte is popped
    for (int i = 0; i < 8; i++) begin
      wbWrite(3'd4, 8'h20);
      waitBusy("busy_fill");
      applyStimulus(1'b0, 8'(8'h30 + i));
    end
    wbRead(3'd6, rd);
    checkOutput("rx_lvl_full", {8'd0, rd}, 16'h0008);
    wbWrite(3'd4, 8'h20);
    tick(3);
    checkOutput("rx_full_block", {15'd0, bc_read}, 16'd0);
    wbRead(3'd4, rd);
    checkOutput("sr_rx_full", {8'd0, rd}, 16'h0003);
    wbRead(3'd3, rd);
    checkOutput("rx_pop_30", {8'd0, rd}, 16'h0030);
    tick(1);
    checkOutput("issue_after_pop", {15'd0, bc_read}, 16'd1);
    applyStimulus(1'b1, 8'hEE);
    for (int i = 0; i < 7; i++) rxExpect[i] = 8'(8'h31 + i);
    rxExpect[7] = 8'hEE;
    for (int i = 0; i < 8; i++) begin
      wbRead(3'd3, rd);
      checkOutput($sformatf("rx_drain_%0d", i), {8'd0, rd}, {8'd0, rxExpect[i]});
    end
    wbRead(3'd4, rd);
    checkOutput("sr_rxack", {8'd0, rd}, 16'h0085);
    wbWrite(3'd6, 8'h01);

    // Arbitration loss
    pushCmd(8'h90, 8'h40);
    waitBusy("busy_al");
    for (int i = 0; i < 3; i++) wbWrite(3'd4, 8'h10);
    wbRead(3'd5, rd);
    checkOutput("al_pre_lvl", {8'd0, rd}, 16'h0003);
    @(negedge wb_clk_i);
    bc_al = 1'b1;
    @(negedge wb_clk_i);
    bc_al = 1'b0;
    checkOutput("al_idle", {15'd0, bc_write}, 16'd0);
    wbRead(3'd5, rd);
    checkOutput("al_lvl", {8'd0, rd}, 16'h0000);
    wbRead(3'd4, rd);
    checkOutput("sr_al", {8'd0, rd}, 16'h00A5);
    wbWrite(3'd6, 8'h01);
    wbWrite(3'd4, 8'h90);
    waitBusy("busy_al_clr");
    wbRead(3'd4, rd);
    checkOutput("sr_al_clr", {8'd0, rd}, 16'h0086);
    applyStimulus(1'b0, 8'h00);
    wbWrite(3'd6, 8'h01);

    // NACK on a write with two commands queued
    pushCmd(8'h90, 8'h50);
    waitBusy("busy_nack");
    wbWrite(3'd4, 8'h10);
    wbWrite(3'd4, 8'h10);
    applyStimulus(1'b1, 8'h00);
`ifdef I2C_NACK_ABORT_EN
    wbRead(3'd5, rd);
    checkOutput("nack_lvl", {8'd0, rd}, 16'h0000);
    wbRead(3'd4, rd);
    checkOutput("sr_nack", {8'd0, rd}, 16'h0095);
    wbWrite(3'd6, 8'h01);
    wbRead(3'd4, rd);
    checkOutput("sr_nack_clr", {8'd0, rd}, 16'h0084);
`else
    wbRead(3'd5, rd);
    checkOutput("nack_lvl", {8'd0, rd}, 16'h0001);
    wbRead(3'd4, rd);
    checkOutput("sr_nack", {8'd0, rd}, 16'h0086);
    applyStimulus(1'b0, 8'h00);
    waitBusy("busy_nack3");
    checkOutput("nack_third", {15'd0, bc_write}, 16'd1);
    applyStimulus(1'b0, 8'h00);
    wbRead(3'd5, rd);
    checkOutput("nack_done_lvl", {8'd0, rd}, 16'h0000);
    wbWrite(3'd6, 8'h01);
`endif

    // FLUSH empties both FIFOs but leaves the active command running
    pushCmd(8'h20, 8'h00);
    waitBusy("busy_fl_rd");
    applyStimulus(1'b0, 8'h77);
    wbWrite(3'd4, 8'h90);
    waitBusy("busy_fl");
    wbWrite(3'd4, 8'h10);
    wbWrite(3'd4, 8'h10);
    wbRead(3'd5, rd);
    checkOutput("fl_pre_lvl", {8'd0, rd}, 16'h0002);
    wbWrite(3'd6, 8'h02);
    wbRead(3'd5, rd);
    checkOutput("fl_cmd_lvl", {8'd0, rd}, 16'h0000);
    wbRead(3'd6, rd);
    checkOutput("fl_rx_lvl", {8'd0, rd}, 16'h0000);
    checkOutput("fl_active", {15'd0, bc_write}, 16'd1);
    applyStimulus(1'b0, 8'h00);
    wbWrite(3'd6, 8'h01);

    // Reset in the middle of a read command
    pushCmd(8'h20, 8'h00);
    waitBusy("busy_rst");
    checkOutput("pre_rst_read", {15'd0, bc_read}, 16'd1);
    @(negedge wb_clk_i);
    arst_i = 1'b1;
    tick(1);
    checkOutput("mid_rst_read", {15'd0, bc_read}, 16'd0);
    checkOutput("mid_rst_clk_cnt", bc_clk_cnt, 16'hFFFF);
    @(negedge wb_clk_i);
    arst_i = 1'b0;
    wbRead(3'd6, rd);
    checkOutput("mid_rst_rx_lvl", {8'd0, rd}, 16'h0000);
    checkOutput("mid_rst_ena", {15'd0, bc_ena}, 16'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
